// File: rtl/ibex_pmc_responder.sv
// PMC request responder: grants single core requests, owns a bank of event
// counters and returns one response per request after a fixed latency.
module ibex_pmc_responder #(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned CounterWidth = 32,
    parameter int unsigned RespLatency  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pmc_req_i,
    input  logic                   pmc_we_i,
    input  logic [3:0]             pmc_addr_i,
    input  logic [31:0]            pmc_wdata_i,
    output logic                   pmc_gnt_o,
    output logic                   pmc_rvalid_o,
    output logic [31:0]            pmc_rdata_o,
    output logic                   pmc_err_o,
    input  logic [NumCounters-1:0] event_i,
    input  logic [NumCounters-1:0] inhibit_i,
    output logic [NumCounters-1:0] overflow_o
);

    typedef enum logic [1:0] {StIdle, StGnt, StWait, StResp} state_e;

    // WAIT lasts RespLatency-1 cycles: preload with that count minus one.
    localparam logic [3:0] WaitInit = (RespLatency > 1) ? 4'(RespLatency - 2) : 4'd0;

    state_e                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic                    we_q;
    logic [3:0]              addr_q;
    logic [CounterWidth-1:0] wdata_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CounterWidth-1:0] cnt_q [NumCounters];
    logic [NumCounters-1:0]  ovf_q;

    logic                    capture;
    logic                    addr_ok;
    logic                    wr_en;
    logic [CounterWidth-1:0] rd_cnt;

    assign capture = (state_q == StIdle) && pmc_req_i;
    assign addr_ok = ({1'b0, addr_q} < 5'(NumCounters));
    assign wr_en   = (state_q == StGnt) && we_q && addr_ok;

    // Select the addressed counter's registered value for a read.
    always_comb begin
        rd_cnt = '0;
        for (int unsigned i = 0; i < NumCounters; i++) begin
            if (addr_q == 4'(i)) begin
                rd_cnt = cnt_q[i];
            end
        end
    end

    // Next-state logic: response is captured in GNT and held through WAIT.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (pmc_req_i) begin
                    state_d = StGnt;
                end
            end
            StGnt: begin
                err_d   = !addr_ok;
                rdata_d = (!we_q && addr_ok) ? 32'(rd_cnt) : 32'd0;
                wait_d  = WaitInit;
                state_d = (RespLatency > 1) ? StWait : StResp;
            end
            StWait: begin
                if (wait_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, request latch and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                we_q    <= pmc_we_i;
                addr_q  <= pmc_addr_i;
                wdata_q <= pmc_wdata_i[CounterWidth-1:0];
            end
        end
    end

    // Counters: a write wins over a same-cycle event and suppresses overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumCounters; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumCounters; i++) begin
                if (wr_en && (addr_q == 4'(i))) begin
                    cnt_q[i] <= wdata_q;
                    ovf_q[i] <= 1'b0;
                end else if (event_i[i] && !inhibit_i[i]) begin
                    cnt_q[i] <= cnt_q[i] + CounterWidth'(1);
                    ovf_q[i] <= &cnt_q[i];
                end else begin
                    ovf_q[i] <= 1'b0;
                end
            end
        end
    end

    assign pmc_gnt_o    = (state_q == StGnt);
    assign pmc_rvalid_o = (state_q == StResp);
    assign pmc_rdata_o  = pmc_rvalid_o ? rdata_q : 32'd0;
    assign pmc_err_o    = pmc_rvalid_o && err_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ibex_pmc_responder.sv
// Bench for ibex_pmc_responder: a transaction-schedule model checks the
// latency-1 instance every cycle; a latency-4 instance covers WAIT and reset.
module tb_ibex_pmc_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst4_n = 1'b0;
    logic        req = 1'b0;
    logic        req4 = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  ev_s = 4'd0;
    logic [3:0]  inh_s = 4'd0;
    logic [3:0]  zero4 = 4'd0;

    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [3:0]  ovf;
    logic        gnt4, rvalid4, err4;
    logic [31:0] rdata4;
    logic [3:0]  ovf4;

    int tests = 0;
    int fails = 0;
    int tick = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    ibex_pmc_responder #(.NumCounters(4), .CounterWidth(32), .RespLatency(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pmc_req_i(req), .pmc_we_i(we), .pmc_addr_i(addr),
        .pmc_wdata_i(wdata), .pmc_gnt_o(gnt), .pmc_rvalid_o(rvalid), .pmc_rdata_o(rdata),
        .pmc_err_o(err), .event_i(ev_s), .inhibit_i(inh_s), .overflow_o(ovf)
    );

    ibex_pmc_responder #(.NumCounters(4), .CounterWidth(32), .RespLatency(4)) dut4 (
        .clk_i(clk), .rst_ni(rst4_n), .pmc_req_i(req4), .pmc_we_i(we), .pmc_addr_i(addr),
        .pmc_wdata_i(wdata), .pmc_gnt_o(gnt4), .pmc_rvalid_o(rvalid4), .pmc_rdata_o(rdata4),
        .pmc_err_o(err4), .event_i(zero4), .inhibit_i(zero4), .overflow_o(ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the latency-1 instance: a request seen while no transaction is
    // pending is granted next cycle and answered RespLatency cycles later.
    localparam int ML = 1;
    logic [31:0] m_cnt [4];
    logic [3:0]  m_ovf = 4'd0;
    int          m_cyc = 0;
    int          m_gnt_at = -1;
    int          m_resp_at = -1;
    logic        m_we = 1'b0;
    logic [3:0]  m_addr = 4'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;

    initial begin
        int wr_idx;
        for (int i = 0; i < 4; i++) m_cnt[i] = 32'd0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 32'd0;
                m_ovf = 4'd0;
                m_gnt_at = -1;
                m_resp_at = -1;
                m_rdata = 32'd0;
                m_err = 1'b0;
            end else begin
                wr_idx = -1;
                if (m_cyc == m_gnt_at) begin
                    m_rdata = 32'd0;
                    m_err = (m_addr >= 4'd4);
                    if (!m_err && m_we) wr_idx = int'(m_addr);
                    if (!m_err && !m_we) m_rdata = m_cnt[m_addr];
                end
                for (int i = 0; i < 4; i++) begin
                    if (i == wr_idx) begin
                        m_cnt[i] = m_wdata;
                        m_ovf[i] = 1'b0;
                    end else if (ev_s[i] && !inh_s[i]) begin
                        m_ovf[i] = (m_cnt[i] == 32'hFFFF_FFFF);
                        m_cnt[i] = m_cnt[i] + 32'd1;
                    end else begin
                        m_ovf[i] = 1'b0;
                    end
                end
                if (req && (m_cyc > m_resp_at)) begin
                    m_gnt_at = m_cyc + 1;
                    m_resp_at = m_cyc + 1 + ML;
                    m_we = we;
                    m_addr = addr;
                    m_wdata = wdata;
                end
            end
            m_cyc++;
        end
    end

    // Per-cycle comparison of the latency-1 instance against the model.
    initial begin
        logic e_gnt, e_rv, e_err;
        logic [31:0] e_rd;
        logic [3:0] e_ovf;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_gnt = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rd = 32'd0; e_ovf = 4'd0;
            end else begin
                e_gnt = (m_cyc == m_gnt_at);
                e_rv = (m_cyc == m_resp_at);
                e_rd = e_rv ? m_rdata : 32'd0;
                e_err = e_rv && m_err;
                e_ovf = m_ovf;
            end
            check("cyc_gnt", 32'(gnt), 32'(e_gnt));
            check("cyc_rvalid", 32'(rvalid), 32'(e_rv));
            check("cyc_rdata", rdata, e_rd);
            check("cyc_err", 32'(err), 32'(e_err));
            check("cyc_overflow", 32'(ovf), 32'(e_ovf));
        end
    end

    // One request: req held for two cycles (through the expected grant), ev
    // applied to the latency-1 instance in the expected grant cycle.
    task automatic txn(input bit d4, input logic we_v, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] ev,
                       output logic [31:0] rd, output logic er, output int dg, output int dr);
        int t0;
        bit seen;
        dg = -1; dr = -1; rd = 32'd0; er = 1'b0;
        if (d4) req4 = 1'b1; else req = 1'b1;
        we = we_v; addr = a; wdata = wd; t0 = tick;
        @(posedge clk); #1;
        ev_s = ev;
        @(negedge clk);
        if ((d4 ? gnt4 : gnt) === 1'b1) dg = tick - t0;
        @(posedge clk); #1;
        req = 1'b0; req4 = 1'b0; ev_s = 4'd0; we = 1'b0; addr = 4'd0; wdata = 32'd0;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if ((d4 ? rvalid4 : rvalid) === 1'b1) begin
                seen = 1'b1;
                dr = tick - t0;
                rd = d4 ? rdata4 : rdata;
                er = d4 ? err4 : err;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input bit d4, input logic [3:0] a, input logic [31:0] exp,
                          input string name);
        logic [31:0] rd;
        logic er;
        int dg, dr;
        txn(d4, 1'b0, a, 32'd0, 4'd0, rd, er, dg, dr);
        check({name, "_rdata"}, rd, exp);
        check({name, "_gnt_lat"}, 32'(dg), 32'd1);
        check({name, "_err"}, 32'(er), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int dg, dr, rvc;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst4_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Reset state: every counter reads zero.
        for (int i = 0; i < 4; i++) rd_chk(1'b0, 4'(i), 32'd0, "reset_read");

        // Write ctr1, then read it back.
        txn(1'b0, 1'b1, 4'd1, 32'h1234, 4'd0, rd, er, dg, dr);
        check("wr1_gnt_lat", 32'(dg), 32'd1);
        check("wr1_rvalid_lat", 32'(dr), 32'd2);
        check("wr1_rdata", rd, 32'd0);
        check("wr1_err", 32'(er), 32'd0);
        rd_chk(1'b0, 4'd1, 32'h1234, "rd1");

        // Five events on ctr0 with the third inhibited.
        ev_s = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            inh_s = (k == 2) ? 4'b0001 : 4'b0000;
            @(posedge clk); #1;
        end
        ev_s = 4'd0;
        inh_s = 4'd0;
        rd_chk(1'b0, 4'd0, 32'd4, "rd0_events");

        // Wrap of ctr2 and its one-cycle overflow pulse.
        txn(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'd0, rd, er, dg, dr);
        ev_s = 4'b0100;
        @(posedge clk); #1;
        ev_s = 4'd0;
        @(negedge clk);
        check("ovf2_pulse", 32'(ovf[2]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ovf2_clear", 32'(ovf[2]), 32'd0);
        @(posedge clk); #1;
        rd_chk(1'b0, 4'd2, 32'd0, "rd2_wrapped");

        // Write to ctr3 with same-cycle events on ctr3 and ctr0.
        txn(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'b1001, rd, er, dg, dr);
        check("wr3_gnt_lat", 32'(dg), 32'd1);
        rd_chk(1'b0, 4'd3, 32'hFFFF_FFFF, "rd3_write_wins");
        rd_chk(1'b0, 4'd0, 32'd5, "rd0_other_event");

        // Out-of-range address: read and write both error, nothing changes.
        txn(1'b0, 1'b0, 4'd7, 32'd0, 4'd0, rd, er, dg, dr);
        check("rd7_err", 32'(er), 32'd1);
        check("rd7_rdata", rd, 32'd0);
        txn(1'b0, 1'b1, 4'd7, 32'hDEAD, 4'd0, rd, er, dg, dr);
        check("wr7_err", 32'(er), 32'd1);
        check("wr7_rdata", rd, 32'd0);
        rd_chk(1'b0, 4'd1, 32'h1234, "rd1_after_err");
        rd_chk(1'b0, 4'd3, 32'hFFFF_FFFF, "rd3_after_err");

        // Latency-4 instance: normal write and read timing.
        txn(1'b1, 1'b1, 4'd1, 32'h55, 4'd0, rd, er, dg, dr);
        check("l4_wr_gnt_lat", 32'(dg), 32'd1);
        check("l4_wr_rvalid_lat", 32'(dr), 32'd5);
        txn(1'b1, 1'b0, 4'd1, 32'd0, 4'd0, rd, er, dg, dr);
        check("l4_rd_rvalid_lat", 32'(dr), 32'd5);
        check("l4_rd_rdata", rd, 32'h55);

        // Latency-4 instance: reset during WAIT abandons the read.
        req4 = 1'b1;
        we = 1'b0;
        addr = 4'd1;
        @(posedge clk); #1;
        @(negedge clk);
        check("l4_abort_gnt", 32'(gnt4), 32'd1);
        @(posedge clk); #1;
        req4 = 1'b0;
        addr = 4'd0;
        rst4_n = 1'b0;
        @(negedge clk);
        check("l4_abort_rvalid_in_reset", 32'(rvalid4), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst4_n = 1'b1;
        rvc = 0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid4 !== 1'b0) rvc++;
        end
        check("l4_abort_no_rvalid", 32'(rvc), 32'd0);
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 4'd1, 32'd0, 4'd0, rd, er, dg, dr);
        check("l4_post_reset_gnt_lat", 32'(dg), 32'd1);
        check("l4_post_reset_rvalid_lat", 32'(dr), 32'd5);
        check("l4_post_reset_rdata", rd, 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests,
                 fails);
        $fatal(1);
    end

endmodule
